// File: rtl/lcd_hd44780_driver_if.sv
// Request channel between the LSU's LCD register and lcd_hd44780_driver.
//   valid : master -> slave, request present; payload must stay stable until accepted
//   rs    : master -> slave, 0 = instruction register, 1 = data register
//   data  : master -> slave, byte to write
//   ready : slave -> master, slave can take a request this cycle
// Handshake: a request transfers on a rising clock edge where valid && ready are both 1.
// The master holds valid and payload until that edge. The slave may drop ready at any time,
// and ready does not depend on valid. A request offered while ready=0 is not stored.
interface lcd_hd44780_driver_if;
  logic       valid;
  logic       rs;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output rs, output data, input ready);
  modport slave  (input valid, input rs, input data, output ready);
endinterface

// File: rtl/lcd_hd44780_driver.sv
// HD44780 write-only bus driver.
// On its own it runs the power-up init sequence: 38,38,38,38,0C,01,06, all with RS=0.
// It then accepts byte writes on a valid/ready channel. Each write becomes one E-strobed bus
// cycle with programmable setup, pulse, hold and execution wait.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   req           : request channel (slave modport), see lcd_hd44780_driver_if
//   init_done_o   : init sequence finished (sticky until reset)
//   lcd_data_o    : DB[7:0]
//   lcd_rs_o      : RS
//   lcd_rw_o      : RW, always 0
//   lcd_en_o      : E
//   lcd_on_o      : panel power enable
//   dbg_state_o   : current FSM state, for observation
module lcd_hd44780_driver #(
  parameter int T_PWRUP = 750000,
  parameter int T_SETUP = 4,
  parameter int T_EPW   = 16,
  parameter int T_HOLD  = 4,
  parameter int T_EXEC  = 2000,
  parameter int T_CLEAR = 82000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  lcd_hd44780_driver_if.slave req,
  output logic                init_done_o,
  output logic [7:0]          lcd_data_o,
  output logic                lcd_rs_o,
  output logic                lcd_rw_o,
  output logic                lcd_en_o,
  output logic                lcd_on_o,
  output logic [2:0]          dbg_state_o
);

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max_i(max_i(max_i(T_PWRUP, T_SETUP), max_i(T_EPW, T_HOLD)),
                               max_i(T_EXEC, T_CLEAR));
  localparam int CW = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] LD_PWRUP = CW'(T_PWRUP - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_EPW   = CW'(T_EPW - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LD_CLEAR = CW'(T_CLEAR - 1);

  localparam logic [2:0] INIT_LAST = 3'd7;  // index after the 7th ROM entry has been loaded

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_LOAD  = 3'd1,
    S_IDLE  = 3'd2,
    S_SETUP = 3'd3,
    S_PULSE = 3'd4,
    S_HOLD  = 3'd5,
    S_EXEC  = 3'd6
  } state_t;

  function automatic logic [7:0] init_rom(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2, 3'd3: return 8'h38;  // function set: 8-bit, 2-line, 5x8
      3'd4:                   return 8'h0C;  // display on, cursor off
      3'd5:                   return 8'h01;  // clear
      default:                return 8'h06;  // entry mode: increment
    endcase
  endfunction

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic          done_q;
  logic          ready_q;
  logic [7:0]    data_q;
  logic          rs_q;
  logic          en_q;
  logic          on_q;
  logic          cnt_zero;
  logic          long_exec;

  assign cnt_zero  = (cnt_q == '0);
  // Clear and Home need the long execution wait. Every other instruction or data write uses the
  // short wait.
  assign long_exec = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      on_q <= 1'b1;
      case (state_q)
        S_PWRUP: begin
          // The counter leaves reset at 0. The first cycle out of reset (on_q still 0) arms the
          // power-up wait instead of ending it.
          if (!on_q) begin
            cnt_q <= LD_PWRUP;
          end else if (cnt_zero) begin
            state_q <= S_LOAD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_LOAD: begin
          data_q  <= init_rom(idx_q);
          rs_q    <= 1'b0;
          idx_q   <= idx_q + 3'd1;
          cnt_q   <= LD_SETUP;
          state_q <= S_SETUP;
        end
        S_IDLE: begin
          if (req.valid && ready_q) begin
            data_q  <= req.data;
            rs_q    <= req.rs;
            ready_q <= 1'b0;
            cnt_q   <= LD_SETUP;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_zero) begin
            en_q    <= 1'b1;
            cnt_q   <= LD_EPW;
            state_q <= S_PULSE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_PULSE: begin
          if (cnt_zero) begin
            en_q    <= 1'b0;
            cnt_q   <= LD_HOLD;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            cnt_q   <= long_exec ? LD_CLEAR : LD_EXEC;
            state_q <= S_EXEC;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_EXEC: begin
          if (cnt_zero) begin
            if (!done_q && (idx_q != INIT_LAST)) begin
              state_q <= S_LOAD;
            end else begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          en_q    <= 1'b0;
          ready_q <= 1'b0;
          state_q <= S_PWRUP;
        end
      endcase
    end
  end

  assign req.ready   = ready_q;
  assign init_done_o = done_q;
  assign lcd_data_o  = data_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = en_q;
  assign lcd_on_o    = on_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
`timescale 1ns/1ps
module tb_lcd_hd44780_driver;
  localparam int T_PWRUP = 20;
  localparam int T_SETUP = 2;
  localparam int T_EPW   = 3;
  localparam int T_HOLD  = 2;
  localparam int T_EXEC  = 5;
  localparam int T_CLEAR = 9;
  localparam int W       = 9;   // {rs, data}

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_hd44780_driver_if req_if();
  logic       init_done;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [2:0] dbg_state;

  lcd_hd44780_driver #(
    .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_EPW(T_EPW),
    .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req(req_if),
    .init_done_o(init_done), .lcd_data_o(lcd_data), .lcd_rs_o(lcd_rs),
    .lcd_rw_o(lcd_rw), .lcd_en_o(lcd_en), .lcd_on_o(lcd_on), .dbg_state_o(dbg_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           rise_q[$];
  int           n_vec = 0;
  int           n_bad = 0;
  logic [7:0]   rom [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // bus monitor: each E rise pops one expected {rs,data}; bus must hold it for the whole pulse
  logic [W-1:0] cur_exp  = '0;
  logic         en_prev  = 1'b0;
  logic         in_pulse = 1'b0;
  int           pulse_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      en_prev  = 1'b0;
      in_pulse = 1'b0;
    end else begin
      if (lcd_en && !en_prev) begin
        check_eq("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
        else cur_exp = '1;
        check_eq("rw_low", 32'(lcd_rw), 32'd0);
        rise_q.push_back(cyc);
        in_pulse  = 1'b1;
        pulse_len = 0;
      end
      if (lcd_en) begin
        check_eq("bus_during_e", 32'({lcd_rs, lcd_data}), 32'(cur_exp));
        pulse_len++;
      end
      if (!lcd_en && en_prev && in_pulse) begin
        check_eq("e_width", 32'(pulse_len), 32'(T_EPW));
        in_pulse = 1'b0;
      end
      en_prev = lcd_en;
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic push_init();
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, rom[i]});
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input bit keep, output int acc);
    int n = 0;
    req_if.valid = 1'b1;
    req_if.rs    = rs;
    req_if.data  = d;
    exp_q.push_back({rs, d});
    while (!req_if.ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!req_if.ready) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      acc = cyc;
      req_if.valid = 1'b0;
    end else begin
      @(negedge clk);
      acc = cyc;
      check_eq("ready_drop_on_accept", 32'(req_if.ready), 32'd0);
      if (!keep) req_if.valid = 1'b0;
    end
  endtask

  task automatic wait_ready(input int acc, output int rcyc);
    int n = 0;
    while (!req_if.ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!req_if.ready) check_eq("ready_timeout", 32'd0, 32'd1);
    rcyc = cyc - acc + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, acc0, rc, d0, np, n;
    logic [8:0] cmd_tab [7] = '{9'h001, 9'h002, 9'h003, 9'h080, 9'h101, 9'h004, 9'h000};
    int         rdy_tab [7] = '{17, 17, 17, 13, 13, 13, 13};

    req_if.valid = 1'b0;
    req_if.rs    = 1'b0;
    req_if.data  = '0;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_en",    32'(lcd_en), 32'd0);
    check_eq("rst_rs",    32'(lcd_rs), 32'd0);
    check_eq("rst_data",  32'(lcd_data), 32'd0);
    check_eq("rst_ready", 32'(req_if.ready), 32'd0);
    check_eq("rst_done",  32'(init_done), 32'd0);
    check_eq("rst_on",    32'(lcd_on), 32'd0);
    check_eq("rst_rw",    32'(lcd_rw), 32'd0);

    // 1: init sequence
    push_init();
    rise_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check_eq("on_after_release", 32'(lcd_on), 32'd1);
    n = 0;
    while (!init_done && n < 2000) begin
      check_eq("ready_eq_done_init", 32'(req_if.ready), 32'(init_done));
      @(negedge clk);
      n++;
    end
    check_eq("init_done_seen", 32'(init_done), 32'd1);
    check_eq("ready_with_done", 32'(req_if.ready), 32'd1);
    check_eq("init_pulses", 32'(rise_q.size()), 32'd7);
    check_eq("init_q_empty", 32'(exp_q.size()), 32'd0);
    if (rise_q.size() == 7) begin
      for (int i = 0; i < 6; i++)
        check_eq("init_gap", 32'(rise_q[i+1] - rise_q[i]), (rom[i] == 8'h01) ? 32'd17 : 32'd13);
      check_eq("init_last_to_ready", 32'(cyc - rise_q[6]), 32'd10);
    end

    // 2: single data write
    np = rise_q.size();
    d0 = cyc;
    send(1'b1, 8'h41, 1'b0, acc);
    check_eq("accept_latency", 32'(acc - d0), 32'd1);
    wait_ready(acc, rc);
    check_eq("ready_return_41", 32'(rc), 32'd13);
    check_eq("one_pulse_41", 32'(rise_q.size() - np), 32'd1);
    if (rise_q.size() > np) check_eq("e_rise_cycle", 32'(rise_q[np] - acc + 1), 32'd3);

    // 3: command execution times (Clear/Home vs. normal, RS boundary)
    for (int i = 0; i < 7; i++) begin
      send(cmd_tab[i][8], cmd_tab[i][7:0], 1'b0, acc);
      wait_ready(acc, rc);
      check_eq($sformatf("ready_return_%03h", cmd_tab[i]), 32'(rc), 32'(rdy_tab[i]));
    end

    // 4: valid held high across three requests
    send(1'b1, 8'h48, 1'b1, acc0);
    send(1'b1, 8'h49, 1'b1, acc);
    check_eq("b2b_accept_1", 32'(acc - acc0), 32'd13);
    send(1'b1, 8'h21, 1'b0, acc);
    check_eq("b2b_accept_2", 32'(acc - acc0), 32'd26);
    wait_ready(acc, rc);
    check_eq("b2b_q_empty", 32'(exp_q.size()), 32'd0);

    // 5: reset while E is high
    send(1'b1, 8'h5A, 1'b0, acc);
    n = 0;
    while (!lcd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("en_before_reset", 32'(lcd_en), 32'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("en_after_reset", 32'(lcd_en), 32'd0);
    check_eq("done_after_reset", 32'(init_done), 32'd0);
    check_eq("ready_after_reset", 32'(req_if.ready), 32'd0);
    check_eq("state_after_reset", 32'(dbg_state), 32'd0);
    @(negedge clk);
    exp_q.delete();
    push_init();
    rst = 1'b0;

    // 6: request held during init is taken on the first ready cycle
    np = rise_q.size();
    send(1'b1, 8'h55, 1'b0, acc);
    check_eq("accept_after_init", 32'(init_done), 32'd1);
    wait_ready(acc, rc);
    check_eq("reinit_plus_one_pulses", 32'(rise_q.size() - np), 32'd8);
    check_eq("ready_return_55", 32'(rc), 32'd13);
    repeat (5) @(negedge clk);
    check_eq("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
